// File: rtl/mpp_pkg.sv
// Shared definitions for the mpp execution unit: opcodes, ALU function codes,
// FSM state encoding and the multi-cycle opcode classifier.
package mpp_pkg;
  localparam int OP_W  = 4;
  localparam int ALU_W = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'd1;
  localparam logic [OP_W-1:0] OP_LDR  = 4'd2;
  localparam logic [OP_W-1:0] OP_STR  = 4'd3;
  localparam logic [OP_W-1:0] OP_ALU  = 4'd4;
  localparam logic [OP_W-1:0] OP_PUSH = 4'd5;
  localparam logic [OP_W-1:0] OP_POP  = 4'd6;
  localparam logic [OP_W-1:0] OP_IN   = 4'd7;
  localparam logic [OP_W-1:0] OP_OUT  = 4'd8;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_W-1:0] ALU_NOT = 3'd5;
  localparam logic [ALU_W-1:0] ALU_SHL = 3'd6;
  localparam logic [ALU_W-1:0] ALU_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // ALU and POP need a second cycle (operand latch / synchronous stack read).
  function automatic logic is_long(input logic [OP_W-1:0] op);
    return (op == OP_ALU) || (op == OP_POP);
  endfunction
endpackage

// File: rtl/mpp_exec_unit_if.sv
// Command handshake and I/O bundle between the decoder and the execution unit.
interface mpp_exec_unit_if
  import mpp_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int STACK_DEPTH = 16
);
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [OP_W-1:0]                cmd_op;
  logic [$clog2(NUM_REGS)-1:0]    cmd_sel;
  logic [DATA_W-1:0]              cmd_imm;
  logic                           done;
  logic [DATA_W-1:0]              acc;
  logic                           flag_c;
  logic                           flag_z;
  logic [DATA_W-1:0]              in_port;
  logic [DATA_W-1:0]              out_port;
  logic [$clog2(STACK_DEPTH):0]   stack_level;
  logic                           stack_err;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_imm, in_port,
    input  cmd_ready, done, acc, flag_c, flag_z, out_port, stack_level, stack_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_imm, in_port,
    output cmd_ready, done, acc, flag_c, flag_z, out_port, stack_level, stack_err
  );
endinterface

// File: rtl/mpp_alu.sv
// Combinational ALU: result, carry/borrow and zero for one function code.
module mpp_alu
  import mpp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [ALU_W-1:0]  fn_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o,
  output logic              c_o,
  output logic              z_o
);
  logic [DATA_W:0] sum;

  // Function select; logic ops always clear carry.
  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    res_o = '0;
    c_o   = 1'b0;
    case (fn_i)
      ALU_ADD: begin res_o = sum[DATA_W-1:0]; c_o = sum[DATA_W]; end
      ALU_SUB: begin res_o = a_i - b_i; c_o = (a_i < b_i); end
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_NOT: res_o = ~a_i;
      ALU_SHL: begin res_o = {a_i[DATA_W-2:0], 1'b0}; c_o = a_i[DATA_W-1]; end
      ALU_SHR: begin res_o = {1'b0, a_i[DATA_W-1:1]}; c_o = a_i[0]; end
    endcase
  end

  assign z_o = (res_o == '0);
endmodule

// File: rtl/mpp_exec_unit.sv
// mpp execution datapath: accumulator, register bank, C/Z flags, hardware
// stack and output port behind a valid/ready command handshake.
// Optional MPP_EXEC_STACK_GUARD_EN: refuse push-on-full / pop-on-empty and
// raise a sticky stack_err; otherwise the stack pointer wraps.
module mpp_exec_unit
  import mpp_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int STACK_DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  mpp_exec_unit_if.slave bus
);
  localparam int SW = $clog2(NUM_REGS);
  localparam int PW = $clog2(STACK_DEPTH);
  localparam int LW = PW + 1;

  state_t                          state_q, state_d;
  logic [OP_W-1:0]                 op_q;
  logic [SW-1:0]                   sel_q;
  logic [DATA_W-1:0]               imm_q, acc_q, opnd_q, out_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic                            c_q, z_q, done_q, err_q, pop_ok_q;
  logic [LW-1:0]                   lvl_q, lvl_push, lvl_pop;
  logic [DATA_W-1:0]               mem_q [STACK_DEPTH];
  logic [PW-1:0]                   ptr;
  logic                            accept, sel_ok, push_ok, pop_ok;
  logic [DATA_W-1:0]               reg_rd, alu_res;
  logic                            alu_c, alu_z;

  assign accept = bus.cmd_valid && (state_q == ST_IDLE);
  assign ptr    = lvl_q[PW-1:0];
  assign sel_ok = ({1'b0, sel_q} < (SW+1)'(NUM_REGS));
  assign reg_rd = sel_ok ? regs_q[sel_q] : '0;

`ifdef MPP_EXEC_STACK_GUARD_EN
  assign push_ok  = (lvl_q != LW'(STACK_DEPTH));
  assign pop_ok   = (lvl_q != '0);
  assign lvl_push = lvl_q + 1'b1;
  assign lvl_pop  = lvl_q - 1'b1;
`else
  // Unguarded: level lives in the low PW bits and wraps modulo depth.
  assign push_ok  = 1'b1;
  assign pop_ok   = 1'b1;
  assign lvl_push = {1'b0, PW'(ptr + 1'b1)};
  assign lvl_pop  = {1'b0, PW'(ptr - 1'b1)};
`endif

  mpp_alu #(.DATA_W(DATA_W)) u_alu (
    .fn_i  (imm_q[ALU_W-1:0]),
    .a_i   (acc_q),
    .b_i   (opnd_q),
    .res_o (alu_res),
    .c_o   (alu_c),
    .z_o   (alu_z)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;

  // Next state: one EXEC cycle, plus WAIT for the two-cycle opcodes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.cmd_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = is_long(op_q) ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, datapath writeback and retire pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_NOP;
      sel_q    <= '0;
      imm_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      out_q    <= '0;
      regs_q   <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pop_ok_q <= 1'b0;
      lvl_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q  <= bus.cmd_op;
        sel_q <= bus.cmd_sel;
        imm_q <= bus.cmd_imm;
      end
      if (state_q == ST_EXEC) begin
        done_q <= !is_long(op_q);
        case (op_q)
          OP_LDI:  acc_q <= imm_q;
          OP_LDR:  acc_q <= reg_rd;
          OP_STR:  if (sel_ok) regs_q[sel_q] <= acc_q;
          OP_ALU:  opnd_q <= reg_rd;
          OP_PUSH: if (push_ok) lvl_q <= lvl_push; else err_q <= 1'b1;
          OP_POP: begin
            pop_ok_q <= pop_ok;
            if (pop_ok) lvl_q <= lvl_pop; else err_q <= 1'b1;
          end
          OP_IN:   acc_q <= bus.in_port;
          OP_OUT:  out_q <= acc_q;
          default: ;
        endcase
      end
      if (state_q == ST_WAIT) begin
        done_q <= 1'b1;
        if (op_q == OP_ALU) begin
          acc_q <= alu_res;
          c_q   <= alu_c;
          z_q   <= alu_z;
        end else if (pop_ok_q) begin
          acc_q <= mem_q[ptr];
        end
      end
    end
  end

  // Stack storage: written by an accepted push, not reset.
  always_ff @(posedge clk)
    if (state_q == ST_EXEC && op_q == OP_PUSH && push_ok) mem_q[ptr] <= acc_q;

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.done        = done_q;
  assign bus.acc         = acc_q;
  assign bus.flag_c      = c_q;
  assign bus.flag_z      = z_q;
  assign bus.out_port    = out_q;
  assign bus.stack_level = lvl_q;
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_mpp_exec_unit.sv
// Bench for mpp_exec_unit: directed table, stack/reset sequences and random
// commands against an arithmetic reference model.
module tb_mpp_exec_unit;
  import mpp_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int SD = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;

  mpp_exec_unit_if #(.DATA_W(DW), .NUM_REGS(NR), .STACK_DEPTH(SD)) bus ();

  mpp_exec_unit #(.DATA_W(DW), .NUM_REGS(NR), .STACK_DEPTH(SD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    int         sel;
    logic [7:0] imm;
    logic [7:0] acc;
    bit         c;
    bit         z;
    int         lat;
  } vec_t;

  // Reference model state
  int m_acc, m_out, m_lvl;
  int m_regs[NR];
  int m_stk[SD];
  bit m_c, m_z, m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_out = 0; m_lvl = 0; m_c = 0; m_z = 0; m_err = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
  endtask

  task automatic model_exec(input logic [3:0] op, input int sel, input logic [7:0] imm,
                            input logic [7:0] inp);
    int a, b, r;
    bit c;
    a = m_acc; b = m_regs[sel]; r = 0; c = 0;
    case (op)
      OP_LDI: m_acc = imm;
      OP_LDR: m_acc = m_regs[sel];
      OP_STR: m_regs[sel] = m_acc;
      OP_ALU: begin
        case (int'(imm[2:0]))
          0: begin r = a + b; c = (r > 255); end
          1: begin r = a - b + 256; c = (a < b); end
          2: r = a & b;
          3: r = a | b;
          4: r = a ^ b;
          5: r = 255 - a;
          6: begin r = a * 2; c = (a >= 128); end
          default: begin r = a / 2; c = (a % 2 == 1); end
        endcase
        m_acc = r % 256; m_c = c; m_z = (m_acc == 0);
      end
`ifdef MPP_EXEC_STACK_GUARD_EN
      OP_PUSH: if (m_lvl == SD) m_err = 1; else begin m_stk[m_lvl] = m_acc; m_lvl++; end
      OP_POP:  if (m_lvl == 0) m_err = 1; else begin m_lvl--; m_acc = m_stk[m_lvl]; end
`else
      OP_PUSH: begin m_stk[m_lvl] = m_acc; m_lvl = (m_lvl + 1) % SD; end
      OP_POP:  begin m_lvl = (m_lvl + SD - 1) % SD; m_acc = m_stk[m_lvl]; end
`endif
      OP_IN:  m_acc = inp;
      OP_OUT: m_out = m_acc;
      default: ;
    endcase
  endtask

  // Starts on a negedge; returns on the negedge of the cycle where done=1.
  // With keep set, valid stays high and junk fields are driven while busy.
  task automatic issue(input logic [3:0] op, input int sel, input logic [7:0] imm,
                       input bit keep, output int lat, output bit busy_bad);
    int n;
    n = 0;
    busy_bad = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_sel   = 2'(sel);
    bus.cmd_imm   = imm;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", bus.cmd_ready, 1);
    @(negedge clk);
    if (keep) begin
      bus.cmd_op  = OP_LDI;
      bus.cmd_imm = 8'hEE;
      bus.cmd_sel = 2'($urandom_range(0, 3));
    end else begin
      bus.cmd_valid = 1'b0;
    end
    lat = 1;
    while (!bus.done && lat < 8) begin
      if (bus.cmd_ready) busy_bad = 1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic step(input logic [3:0] op, input int sel, input logic [7:0] imm, input bit keep);
    int lat;
    bit bb;
    issue(op, sel, imm, keep, lat, bb);
    model_exec(op, sel, imm, bus.in_port);
    chk($sformatf("op%0d_acc", op), bus.acc, m_acc);
    chk($sformatf("op%0d_c", op), bus.flag_c, m_c);
    chk($sformatf("op%0d_z", op), bus.flag_z, m_z);
    chk($sformatf("op%0d_out", op), bus.out_port, m_out);
    chk($sformatf("op%0d_lvl", op), bus.stack_level, m_lvl);
    chk($sformatf("op%0d_err", op), bus.stack_err, m_err);
    chk($sformatf("op%0d_lat", op), lat, (op == OP_ALU || op == OP_POP) ? 3 : 2);
    chk($sformatf("op%0d_busy", op), bb, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[22];
    int   lat;
    bit   bb, seen;

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_sel = '0;
    bus.cmd_imm = '0; bus.in_port = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_acc", bus.acc, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_c", bus.flag_c, 0);
    chk("rst_z", bus.flag_z, 0);
    chk("rst_out", bus.out_port, 0);
    chk("rst_lvl", bus.stack_level, 0);
    chk("rst_err", bus.stack_err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors: load/store, ADD/SUB carry, SHR zero, logic ops, NOP
    tbl[0]  = '{OP_LDI, 0, 8'h5A, 8'h5A, 0, 0, 2};
    tbl[1]  = '{OP_STR, 2, 8'h00, 8'h5A, 0, 0, 2};
    tbl[2]  = '{OP_LDI, 0, 8'h00, 8'h00, 0, 0, 2};
    tbl[3]  = '{OP_LDR, 2, 8'h00, 8'h5A, 0, 0, 2};
    tbl[4]  = '{OP_LDI, 0, 8'hF0, 8'hF0, 0, 0, 2};
    tbl[5]  = '{OP_STR, 1, 8'h00, 8'hF0, 0, 0, 2};
    tbl[6]  = '{OP_LDI, 0, 8'h20, 8'h20, 0, 0, 2};
    tbl[7]  = '{OP_ALU, 1, 8'h00, 8'h10, 1, 0, 3};
    tbl[8]  = '{OP_ALU, 1, 8'h01, 8'h20, 1, 0, 3};
    tbl[9]  = '{OP_LDI, 0, 8'h01, 8'h01, 1, 0, 2};
    tbl[10] = '{OP_ALU, 0, 8'h07, 8'h00, 1, 1, 3};
    tbl[11] = '{OP_LDI, 0, 8'h33, 8'h33, 1, 1, 2};
    tbl[12] = '{OP_ALU, 1, 8'h02, 8'h30, 0, 0, 3};
    tbl[13] = '{OP_ALU, 2, 8'h04, 8'h6A, 0, 0, 3};
    tbl[14] = '{OP_ALU, 0, 8'h05, 8'h95, 0, 0, 3};
    tbl[15] = '{OP_ALU, 0, 8'h06, 8'h2A, 1, 0, 3};
    tbl[16] = '{OP_ALU, 3, 8'h03, 8'h2A, 0, 0, 3};
    tbl[17] = '{OP_ALU, 2, 8'h01, 8'hD0, 1, 0, 3};
    tbl[18] = '{OP_ALU, 3, 8'h00, 8'hD0, 0, 0, 3};
    tbl[19] = '{OP_LDI, 0, 8'h00, 8'h00, 0, 0, 2};
    tbl[20] = '{OP_ALU, 2, 8'h02, 8'h00, 0, 1, 3};
    tbl[21] = '{4'd11,  0, 8'h77, 8'h00, 0, 1, 2};

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].sel, tbl[i].imm, i[0], lat, bb);
      model_exec(tbl[i].op, tbl[i].sel, tbl[i].imm, bus.in_port);
      chk($sformatf("tbl%0d_acc", i), bus.acc, tbl[i].acc);
      chk($sformatf("tbl%0d_c", i), bus.flag_c, tbl[i].c);
      chk($sformatf("tbl%0d_z", i), bus.flag_z, tbl[i].z);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_busy", i), bb, 0);
    end

    // LIFO order with cmd_valid held high throughout
    step(OP_LDI, 0, 8'h11, 1); step(OP_PUSH, 0, 8'h00, 1);
    step(OP_LDI, 0, 8'h22, 1); step(OP_PUSH, 0, 8'h00, 1);
    step(OP_LDI, 0, 8'h33, 1); step(OP_PUSH, 0, 8'h00, 1);
    chk("lifo_lvl3", bus.stack_level, 3);
    step(OP_POP, 0, 8'h00, 1); chk("lifo_pop1", bus.acc, 8'h33);
    step(OP_POP, 0, 8'h00, 1); chk("lifo_pop2", bus.acc, 8'h22);
    step(OP_POP, 0, 8'h00, 0); chk("lifo_pop3", bus.acc, 8'h11);
    chk("lifo_lvl0", bus.stack_level, 0);

    // 17 pushes on an empty 16-deep stack
    for (int k = 1; k <= 17; k++) begin
      step(OP_LDI, 0, 8'(8'h40 + k), 1);
      step(OP_PUSH, 0, 8'h00, 1);
    end
`ifdef MPP_EXEC_STACK_GUARD_EN
    chk("full_err", bus.stack_err, 1);
    chk("full_lvl", bus.stack_level, 16);
    step(OP_POP, 0, 8'h00, 0);
    chk("full_pop", bus.acc, 8'h50);
`else
    chk("wrap_err", bus.stack_err, 0);
    chk("wrap_lvl", bus.stack_level, 1);
    step(OP_POP, 0, 8'h00, 0);
    chk("wrap_pop", bus.acc, 8'h51);
`endif

    // Reset asserted while an ALU op is in EXEC
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ALU; bus.cmd_sel = 2'd1; bus.cmd_imm = 8'h00;
    chk("abort_ready_pre", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("abort_busy", bus.cmd_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("abort_acc", bus.acc, 0);
    chk("abort_c", bus.flag_c, 0);
    chk("abort_z", bus.flag_z, 0);
    chk("abort_ready", bus.cmd_ready, 1);
    chk("abort_lvl", bus.stack_level, 0);
    chk("abort_err", bus.stack_err, 0);
    seen = 0;
    repeat (2) begin @(negedge clk); if (bus.done) seen = 1; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.done) seen = 1; end
    chk("abort_no_done", seen, 0);
    chk("abort_ready_post", bus.cmd_ready, 1);
    model_reset();

    bus.in_port = 8'hA5;
    step(OP_IN, 0, 8'h00, 0);
    step(OP_OUT, 0, 8'h00, 0);
    chk("io_out", bus.out_port, 8'hA5);

    // Random commands against the model
    for (int k = 0; k < 250; k++) begin
      logic [3:0] op;
      int         sel;
      logic [7:0] imm;
      op = 4'($urandom_range(0, 15));
      if (op == OP_POP && m_lvl == 0) op = OP_PUSH;
      sel = $urandom_range(0, NR - 1);
      imm = 8'($urandom);
      bus.in_port = 8'($urandom);
      step(op, sel, imm, (k != 249) && ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
